// File: rtl/jtopl_timers_if.sv
// Register-bank side bundle for the OPL timer stage: presets, control bits,
// flag clears going in; status flags, IRQ and Timer A overflow coming back.
interface jtopl_timers_if;
    logic [7:0] value_A;
    logic [7:0] value_B;
    logic       load_A;
    logic       load_B;
    logic       flagen_A;
    logic       flagen_B;
    logic       clr_flag_A;
    logic       clr_flag_B;
    logic       flag_A;
    logic       flag_B;
    logic       overflow_A;
    logic       irq_n;

    modport master (
        output value_A, value_B, load_A, load_B,
        output flagen_A, flagen_B, clr_flag_A, clr_flag_B,
        input  flag_A, flag_B, overflow_A, irq_n
    );

    modport slave (
        input  value_A, value_B, load_A, load_B,
        input  flagen_A, flagen_B, clr_flag_A, clr_flag_B,
        output flag_A, flag_B, overflow_A, irq_n
    );
endinterface

// File: rtl/jtopl_timers.sv
// OPL Timer A/B: shared sample-rate prescaler, two 8-bit up-counters with
// reload-on-overflow, status flags with set-over-clear priority and an IRQ line.
module jtopl_timers (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen16,
    input  logic           zero,
    jtopl_timers_if.slave  bus
);

    logic       tick_s;
    logic       tick_a_s;
    logic       tick_b_s;
    logic [3:0] pre_q, pre_d;
    logic [7:0] cnt_a_q, cnt_a_d;
    logic [7:0] cnt_b_q, cnt_b_d;
    logic       load_a_l_q;
    logic       load_b_l_q;
    logic       ovf_a_s;
    logic       ovf_b_s;
    logic       flag_a_q, flag_a_d;
    logic       flag_b_q, flag_b_d;
    logic       ovf_a_q;
    logic       irq_n_q;

    // Returns {overflow, next count}; a load rising edge reloads and suppresses the tick.
    function automatic logic [8:0] timer_next(
        input logic [7:0] cnt,
        input logic [7:0] value,
        input logic       load,
        input logic       load_l,
        input logic       tick
    );
        logic [8:0] res;
        if (load && !load_l) begin
            res = {1'b0, value};
        end else if (load && tick) begin
            if (cnt == 8'hFF) begin
                res = {1'b1, value};
            end else begin
                res = {1'b0, cnt + 8'd1};
            end
        end else begin
            res = {1'b0, cnt};
        end
        return res;
    endfunction

    // Tick decoding, counter next-state and flag next-state.
    always_comb begin
        tick_s   = cen16 & zero;
        tick_a_s = tick_s & (pre_q[1:0] == 2'd3);
        tick_b_s = tick_s & (pre_q == 4'd15);
        pre_d    = pre_q + {3'd0, tick_s};

        {ovf_a_s, cnt_a_d} = timer_next(cnt_a_q, bus.value_A, bus.load_A, load_a_l_q, tick_a_s);
        {ovf_b_s, cnt_b_d} = timer_next(cnt_b_q, bus.value_B, bus.load_B, load_b_l_q, tick_b_s);

        // Set beats clear so an overflow event is never lost.
        if (ovf_a_s && bus.flagen_A) begin
            flag_a_d = 1'b1;
        end else if (bus.clr_flag_A) begin
            flag_a_d = 1'b0;
        end else begin
            flag_a_d = flag_a_q;
        end

        if (ovf_b_s && bus.flagen_B) begin
            flag_b_d = 1'b1;
        end else if (bus.clr_flag_B) begin
            flag_b_d = 1'b0;
        end else begin
            flag_b_d = flag_b_q;
        end
    end

    // State registers; irq_n follows the registered flags one clock later.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q      <= 4'd0;
            cnt_a_q    <= 8'd0;
            cnt_b_q    <= 8'd0;
            load_a_l_q <= 1'b0;
            load_b_l_q <= 1'b0;
            flag_a_q   <= 1'b0;
            flag_b_q   <= 1'b0;
            ovf_a_q    <= 1'b0;
            irq_n_q    <= 1'b1;
        end else begin
            pre_q      <= pre_d;
            cnt_a_q    <= cnt_a_d;
            cnt_b_q    <= cnt_b_d;
            load_a_l_q <= bus.load_A;
            load_b_l_q <= bus.load_B;
            flag_a_q   <= flag_a_d;
            flag_b_q   <= flag_b_d;
            ovf_a_q    <= ovf_a_s;
            irq_n_q    <= ~(flag_a_q | flag_b_q);
        end
    end

    assign bus.flag_A     = flag_a_q;
    assign bus.flag_B     = flag_b_q;
    assign bus.overflow_A = ovf_a_q;
    assign bus.irq_n      = irq_n_q;

endmodule
